// File: rtl/dimm_cmd_decoder.sv
// -----------------------------------------------------------------------------
// dimm_cmd_decoder
//
// Purpose:
//   Samples the DRAM command pins on every rising edge of the command clock,
//   decodes the command, tracks the IDLE/ACTIVE state and open row of every
//   bank, and flags protocol violations. Every output is registered, so a
//   command sampled on edge N shows up on the outputs right after edge N.
//
// Optional feature (macro DIMM_CMD_DEC_TIMING_CHECK_EN):
//   When defined, per-bank tRCD/tRP counters and a global tRFC counter are
//   built in and err_timing reports spacing violations. When undefined, the
//   counters do not exist and err_timing is held at 0.
//
// Ports:
//   clk                     command clock (DRAM ck), rising-edge sampling
//   rst                     asynchronous active-high reset
//   cke, cs_n, ras_n,
//   cas_n, we_n             DRAM command pins
//   ba   [BA_WIDTH]         bank address
//   addr [ADDR_WIDTH]       row/column address, addr[10] is A10
//   cmd_valid               one-cycle strobe for a decoded non-NOP command
//   cmd_code [3]            0 MRS,1 REF,2 PRE,3 PREA,4 ACT,5 WR,6 RD,7 ILLEGAL
//   cmd_ba, cmd_addr        captured ba/addr of the strobed command
//   cmd_ap                  auto-precharge flag (A10) on RD/WR
//   bank_open [NUM_BANKS]   1 = bank ACTIVE (row open)
//   cmd_row                 open row of the addressed bank on RD/WR
//   err_state, err_timing   one-cycle violation pulses
//   err_cnt [16]            saturating count of cycles with any violation
// -----------------------------------------------------------------------------
module dimm_cmd_decoder #(
    parameter int  BA_WIDTH   = 3,
    parameter int  ADDR_WIDTH = 16,
    parameter int  T_RCD      = 4,
    parameter int  T_RP       = 4,
    parameter int  T_RFC      = 32,
    localparam int NUM_BANKS  = 2 ** BA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cke,
    input  logic                  cs_n,
    input  logic                  ras_n,
    input  logic                  cas_n,
    input  logic                  we_n,
    input  logic [BA_WIDTH-1:0]   ba,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  cmd_valid,
    output logic [2:0]            cmd_code,
    output logic [BA_WIDTH-1:0]   cmd_ba,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  cmd_ap,
    output logic [NUM_BANKS-1:0]  bank_open,
    output logic [ADDR_WIDTH-1:0] cmd_row,
    output logic                  err_state,
    output logic                  err_timing,
    output logic [15:0]           err_cnt
);

    typedef enum logic [2:0] {
        CMD_MRS     = 3'd0,
        CMD_REF     = 3'd1,
        CMD_PRE     = 3'd2,
        CMD_PREA    = 3'd3,
        CMD_ACT     = 3'd4,
        CMD_WR      = 3'd5,
        CMD_RD      = 3'd6,
        CMD_ILLEGAL = 3'd7
    } cmd_e;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

    // Bank state and open-row registers
    bank_state_e           bank_state_q [NUM_BANKS];
    bank_state_e           bank_state_d [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] row_q        [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] row_d        [NUM_BANKS];

    // Registered outputs
    logic                  cmd_valid_q,  cmd_valid_d;
    logic [2:0]            cmd_code_q,   cmd_code_d;
    logic [BA_WIDTH-1:0]   cmd_ba_q,     cmd_ba_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q,   cmd_addr_d;
    logic                  cmd_ap_q,     cmd_ap_d;
    logic [ADDR_WIDTH-1:0] cmd_row_q,    cmd_row_d;
    logic                  err_state_q,  err_state_d;
    logic                  err_timing_q, err_timing_d;
    logic [15:0]           err_cnt_q,    err_cnt_d;

    // Decode / check intermediates
    logic                  cmd_hit;
    cmd_e                  code;
    logic                  sel_open;
    logic                  any_open;
    logic                  state_viol;
    logic                  timing_viol;
    logic [ADDR_WIDTH-1:0] open_row;

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_open[i] = (bank_state_q[i] == BANK_ACTIVE);
        end
    end

    // Command decode, bank FSM next state and state-rule checking
    always_comb begin
        cmd_hit      = 1'b0;
        code         = CMD_MRS;
        sel_open     = (bank_state_q[ba] == BANK_ACTIVE);
        any_open     = |bank_open;
        state_viol   = 1'b0;
        open_row     = '0;
        bank_state_d = bank_state_q;
        row_d        = row_q;

        if (cke && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b000:  code = CMD_MRS;
                3'b001:  code = CMD_REF;
                3'b010:  code = addr[10] ? CMD_PREA : CMD_PRE;
                3'b011:  code = CMD_ACT;
                3'b100:  code = CMD_WR;
                3'b101:  code = CMD_RD;
                3'b110:  code = CMD_ILLEGAL;
                default: code = CMD_MRS;
            endcase
            // 111 is NOP: not strobed
            cmd_hit = ({ras_n, cas_n, we_n} != 3'b111);
        end

        if (cmd_hit) begin
            case (code)
                CMD_MRS, CMD_REF: begin
                    // mode-register writes and refresh need every bank closed
                    state_viol = any_open;
                end
                CMD_PRE: begin
                    // precharging an already idle bank is legal and harmless
                    bank_state_d[ba] = BANK_IDLE;
                end
                CMD_PREA: begin
                    for (int i = 0; i < NUM_BANKS; i++) begin
                        bank_state_d[i] = BANK_IDLE;
                    end
                end
                CMD_ACT: begin
                    // a second ACT keeps the bank on its original row
                    if (sel_open) begin
                        state_viol = 1'b1;
                    end else begin
                        bank_state_d[ba] = BANK_ACTIVE;
                        row_d[ba]        = addr;
                    end
                end
                CMD_WR, CMD_RD: begin
                    if (!sel_open) begin
                        state_viol = 1'b1;
                    end else begin
                        // row reported is the one open before this command
                        open_row = row_q[ba];
                        if (addr[10]) begin
                            bank_state_d[ba] = BANK_IDLE;
                        end
                    end
                end
                default: begin
                    state_viol = 1'b1;
                end
            endcase
        end
    end

`ifdef DIMM_CMD_DEC_TIMING_CHECK_EN
    // Each counter is loaded with T-1 on its starting command and counts down
    // to 0; a non-zero value when a dependent command arrives means fewer than
    // T cycles have passed since the starting command was sampled.
    localparam int RCD_W = (T_RCD > 1) ? $clog2(T_RCD) : 1;
    localparam int RP_W  = (T_RP  > 1) ? $clog2(T_RP)  : 1;
    localparam int RFC_W = (T_RFC > 1) ? $clog2(T_RFC) : 1;
    localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'(T_RCD - 1);
    localparam logic [RP_W-1:0]  RP_LOAD  = RP_W'(T_RP - 1);
    localparam logic [RFC_W-1:0] RFC_LOAD = RFC_W'(T_RFC - 1);

    logic [RCD_W-1:0] rcd_q [NUM_BANKS];
    logic [RCD_W-1:0] rcd_d [NUM_BANKS];
    logic [RP_W-1:0]  rp_q  [NUM_BANKS];
    logic [RP_W-1:0]  rp_d  [NUM_BANKS];
    logic [RFC_W-1:0] rfc_q;
    logic [RFC_W-1:0] rfc_d;

    always_comb begin
        timing_viol = 1'b0;
        rfc_d       = (rfc_q != '0) ? rfc_q - RFC_W'(1) : '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            rcd_d[i] = (rcd_q[i] != '0) ? rcd_q[i] - RCD_W'(1) : '0;
            rp_d[i]  = (rp_q[i]  != '0) ? rp_q[i]  - RP_W'(1)  : '0;
            // tRCD starts only on an ACT that actually opened the bank
            if (bank_state_q[i] == BANK_IDLE && bank_state_d[i] == BANK_ACTIVE) begin
                rcd_d[i] = RCD_LOAD;
            end
            // tRP starts on any PRE/PREA aimed at the bank, or on the
            // auto-precharge that closed it
            if ((cmd_hit && (code == CMD_PREA ||
                             (code == CMD_PRE && ba == BA_WIDTH'(i)))) ||
                (bank_state_q[i] == BANK_ACTIVE && bank_state_d[i] == BANK_IDLE)) begin
                rp_d[i] = RP_LOAD;
            end
        end
        if (cmd_hit && code == CMD_REF) begin
            rfc_d = RFC_LOAD;
        end

        if (cmd_hit) begin
            if (rfc_q != '0) begin
                timing_viol = 1'b1;
            end
            if ((code == CMD_RD || code == CMD_WR) && rcd_q[ba] != '0) begin
                timing_viol = 1'b1;
            end
            if (code == CMD_ACT && rp_q[ba] != '0) begin
                timing_viol = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                rcd_q[i] <= '0;
                rp_q[i]  <= '0;
            end
            rfc_q <= '0;
        end else begin
            rcd_q <= rcd_d;
            rp_q  <= rp_d;
            rfc_q <= rfc_d;
        end
    end
`else
    assign timing_viol = 1'b0;
`endif

    // Output register next values; qualified fields read 0 when no command
    always_comb begin
        cmd_valid_d  = cmd_hit;
        cmd_code_d   = cmd_hit ? code : 3'd0;
        cmd_ba_d     = cmd_hit ? ba   : '0;
        cmd_addr_d   = cmd_hit ? addr : '0;
        cmd_ap_d     = cmd_hit && (code == CMD_RD || code == CMD_WR) && addr[10];
        cmd_row_d    = open_row;
        err_state_d  = state_viol;
        err_timing_d = timing_viol;
        err_cnt_d    = err_cnt_q;
        // both kinds of violation in one cycle still count once
        if ((state_viol || timing_viol) && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state_q[i] <= BANK_IDLE;
                row_q[i]        <= '0;
            end
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= 3'd0;
            cmd_ba_q     <= '0;
            cmd_addr_q   <= '0;
            cmd_ap_q     <= 1'b0;
            cmd_row_q    <= '0;
            err_state_q  <= 1'b0;
            err_timing_q <= 1'b0;
            err_cnt_q    <= 16'd0;
        end else begin
            bank_state_q <= bank_state_d;
            row_q        <= row_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            cmd_ba_q     <= cmd_ba_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_ap_q     <= cmd_ap_d;
            cmd_row_q    <= cmd_row_d;
            err_state_q  <= err_state_d;
            err_timing_q <= err_timing_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign cmd_ba     = cmd_ba_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_ap     = cmd_ap_q;
    assign cmd_row    = cmd_row_q;
    assign err_state  = err_state_q;
    assign err_timing = err_timing_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_dimm_cmd_decoder.sv
`timescale 1ns/1ps
module tb_dimm_cmd_decoder;

    localparam int BA_WIDTH   = 3;
    localparam int ADDR_WIDTH = 16;
    localparam int NUM_BANKS  = 8;
    localparam int T_RCD      = 4;
    localparam int T_RP       = 4;
    localparam int T_RFC      = 32;
`ifdef DIMM_CMD_DEC_TIMING_CHECK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif

    // {ras_n, cas_n, we_n} pin patterns
    localparam logic [2:0] P_MRS = 3'b000;
    localparam logic [2:0] P_REF = 3'b001;
    localparam logic [2:0] P_PRE = 3'b010;
    localparam logic [2:0] P_ACT = 3'b011;
    localparam logic [2:0] P_WR  = 3'b100;
    localparam logic [2:0] P_RD  = 3'b101;
    localparam logic [2:0] P_ILL = 3'b110;
    localparam logic [2:0] P_NOP = 3'b111;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  cke = 1'b1;
    logic                  cs_n = 1'b0;
    logic                  ras_n = 1'b1;
    logic                  cas_n = 1'b1;
    logic                  we_n = 1'b1;
    logic [BA_WIDTH-1:0]   ba = '0;
    logic [ADDR_WIDTH-1:0] addr = '0;
    logic                  cmd_valid;
    logic [2:0]            cmd_code;
    logic [BA_WIDTH-1:0]   cmd_ba;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_ap;
    logic [NUM_BANKS-1:0]  bank_open;
    logic [ADDR_WIDTH-1:0] cmd_row;
    logic                  err_state;
    logic                  err_timing;
    logic [15:0]           err_cnt;

    always #5 clk = ~clk;

    dimm_cmd_decoder #(
        .BA_WIDTH   (BA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .T_RCD      (T_RCD),
        .T_RP       (T_RP),
        .T_RFC      (T_RFC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cke        (cke),
        .cs_n       (cs_n),
        .ras_n      (ras_n),
        .cas_n      (cas_n),
        .we_n       (we_n),
        .ba         (ba),
        .addr       (addr),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ba     (cmd_ba),
        .cmd_addr   (cmd_addr),
        .cmd_ap     (cmd_ap),
        .bank_open  (bank_open),
        .cmd_row    (cmd_row),
        .err_state  (err_state),
        .err_timing (err_timing),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        logic                  valid;
        logic [2:0]            code;
        logic [BA_WIDTH-1:0]   ba;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  ap;
        logic [ADDR_WIDTH-1:0] row;
        logic [NUM_BANKS-1:0]  open;
        logic                  es;
        logic                  et;
        logic [15:0]           cnt;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_en = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model: bank state plus timestamps of the last ACT/PRE per
    // bank and the last REF, all in units of sampled command slots.
    bit                    m_open [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] m_row  [NUM_BANKS];
    int                    act_t  [NUM_BANKS];
    int                    pre_t  [NUM_BANKS];
    int                    ref_t;
    int                    t_now;
    logic [15:0]           m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_BANKS; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = '0;
            act_t[i]  = -1000;
            pre_t[i]  = -1000;
        end
        ref_t = -1000;
        t_now = 0;
        m_cnt = 16'd0;
    endtask

    // Drive one command slot at the falling edge and predict the outputs that
    // follow the next rising edge.
    task automatic drive(input logic c_cke, input logic c_csn, input logic [2:0] pins,
                         input int b, input int a);
        exp_t e;
        logic [ADDR_WIDTH-1:0] av;
        @(negedge clk);
        cke = c_cke;
        cs_n = c_csn;
        {ras_n, cas_n, we_n} = pins;
        ba = BA_WIDTH'(b);
        av = ADDR_WIDTH'(a);
        addr = av;

        e.valid = c_cke && !c_csn && (pins != P_NOP);
        e.code = 3'd0; e.ba = '0; e.addr = '0; e.ap = 1'b0; e.row = '0;
        e.es = 1'b0; e.et = 1'b0;
        if (e.valid) begin
            case (pins)
                P_MRS:   e.code = 3'd0;
                P_REF:   e.code = 3'd1;
                P_PRE:   e.code = av[10] ? 3'd3 : 3'd2;
                P_ACT:   e.code = 3'd4;
                P_WR:    e.code = 3'd5;
                P_RD:    e.code = 3'd6;
                default: e.code = 3'd7;
            endcase
            e.ba = BA_WIDTH'(b);
            e.addr = av;
            if (e.code == 3'd5 || e.code == 3'd6) begin
                e.ap = av[10];
                e.row = m_open[b] ? m_row[b] : '0;
            end
            case (e.code)
                3'd0, 3'd1: for (int i = 0; i < NUM_BANKS; i++) if (m_open[i]) e.es = 1'b1;
                3'd4:       e.es = m_open[b];
                3'd5, 3'd6: e.es = !m_open[b];
                3'd7:       e.es = 1'b1;
                default:    e.es = 1'b0;
            endcase
            if (TCHK) begin
                if (t_now - ref_t < T_RFC) e.et = 1'b1;
                if ((e.code == 3'd5 || e.code == 3'd6) && t_now - act_t[b] < T_RCD) e.et = 1'b1;
                if (e.code == 3'd4 && t_now - pre_t[b] < T_RP) e.et = 1'b1;
            end
            case (e.code)
                3'd1: ref_t = t_now;
                3'd2: begin m_open[b] = 1'b0; pre_t[b] = t_now; end
                3'd3: for (int i = 0; i < NUM_BANKS; i++) begin
                          m_open[i] = 1'b0;
                          pre_t[i] = t_now;
                      end
                3'd4: if (!m_open[b]) begin
                          m_open[b] = 1'b1;
                          m_row[b] = av;
                          act_t[b] = t_now;
                      end
                3'd5, 3'd6: if (av[10] && m_open[b]) begin
                          m_open[b] = 1'b0;
                          pre_t[b] = t_now;
                      end
                default: ;
            endcase
        end
        if ((e.es || e.et) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        e.cnt = m_cnt;
        for (int i = 0; i < NUM_BANKS; i++) e.open[i] = m_open[i];
        t_now++;
        if (sb_en) sb_q.push_back(e);
    endtask

    task automatic cmd(input logic [2:0] pins, input int b, input int a);
        drive(1'b1, 1'b0, pins, b, a);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cmd(P_NOP, 0, 0);
    endtask

    // Wait for the edge that samples the last driven command, then look
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Assert reset now (any time, edge-aligned or not) and expect every
    // output to clear immediately, then release on a falling edge.
    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        sb_q.delete();
        #1;
        check_eq("rst_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_code",  32'(cmd_code),  32'd0);
        check_eq("rst_ba",    32'(cmd_ba),    32'd0);
        check_eq("rst_addr",  32'(cmd_addr),  32'd0);
        check_eq("rst_ap",    32'(cmd_ap),    32'd0);
        check_eq("rst_open",  32'(bank_open), 32'd0);
        check_eq("rst_row",   32'(cmd_row),   32'd0);
        check_eq("rst_es",    32'(err_state), 32'd0);
        check_eq("rst_et",    32'(err_timing),32'd0);
        check_eq("rst_cnt",   32'(err_cnt),   32'd0);
        @(negedge clk);
        cke = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = P_NOP; ba = '0; addr = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply_reset();
    endtask

    // Scoreboard consumer: one expectation per sampled command slot
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("sb_valid", 32'(cmd_valid), 32'(e.valid));
                if (e.valid) begin
                    check_eq("sb_code", 32'(cmd_code), 32'(e.code));
                    check_eq("sb_ba",   32'(cmd_ba),   32'(e.ba));
                    check_eq("sb_addr", 32'(cmd_addr), 32'(e.addr));
                end
                check_eq("sb_ap",   32'(cmd_ap),     32'(e.ap));
                check_eq("sb_row",  32'(cmd_row),    32'(e.row));
                check_eq("sb_open", 32'(bank_open),  32'(e.open));
                check_eq("sb_es",   32'(err_state),  32'(e.es));
                check_eq("sb_et",   32'(err_timing), 32'(e.et));
                check_eq("sb_cnt",  32'(err_cnt),    32'(e.cnt));
            end
        end
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        model_reset();
        do_reset();

        // ACT then RD four slots later: clean access
        cmd(P_ACT, 2, 16'h1234);
        settle();
        check_eq("act_code", 32'(cmd_code), 32'd4);
        check_eq("act_open", 32'(bank_open), 32'h04);
        nops(3);
        cmd(P_RD, 2, 16'h0010);
        settle();
        check_eq("rd_code", 32'(cmd_code), 32'd6);
        check_eq("rd_row",  32'(cmd_row),  32'h1234);
        check_eq("rd_open", 32'(bank_open), 32'h04);
        check_eq("rd_errs", 32'({err_state, err_timing}), 32'd0);

        // reset discards open rows: a fresh ACT to bank 2 is legal
        do_reset();
        cmd(P_ACT, 2, 16'h0777);
        settle();
        check_eq("post_rst_es",   32'(err_state), 32'd0);
        check_eq("post_rst_open", 32'(bank_open), 32'h04);

        // RD two slots after ACT: tRCD violation only with timing checks
        do_reset();
        cmd(P_ACT, 1, 16'h0055);
        nops(1);
        cmd(P_RD, 1, 16'h0000);
        settle();
        check_eq("rcd_et",  32'(err_timing), 32'(TCHK));
        check_eq("rcd_cnt", 32'(err_cnt),    32'(TCHK));

        // RD to an idle bank
        do_reset();
        cmd(P_RD, 5, 16'h0000);
        settle();
        check_eq("idle_rd_es",   32'(err_state), 32'd1);
        check_eq("idle_rd_cnt",  32'(err_cnt),   32'd1);
        check_eq("idle_rd_open", 32'(bank_open), 32'd0);

        // PREA closes all, REF afterwards is clean, ACT inside tRFC flagged
        do_reset();
        cmd(P_ACT, 0, 16'h0100);
        cmd(P_ACT, 3, 16'h0200);
        settle();
        check_eq("two_open", 32'(bank_open), 32'h09);
        nops(1);
        cmd(P_PRE, 0, 16'h0400);
        settle();
        check_eq("prea_code", 32'(cmd_code), 32'd3);
        check_eq("prea_open", 32'(bank_open), 32'h00);
        nops(3);
        cmd(P_REF, 0, 0);
        settle();
        check_eq("ref_errs", 32'({err_state, err_timing}), 32'd0);
        nops(9);
        cmd(P_ACT, 0, 16'h0300);
        settle();
        check_eq("rfc_et", 32'(err_timing), 32'(TCHK));

        // WR with auto-precharge, then CKE low / CS_n high suppress commands
        do_reset();
        cmd(P_ACT, 0, 16'h0042);
        nops(3);
        cmd(P_WR, 0, 16'h0400);
        settle();
        check_eq("wrap_ap",   32'(cmd_ap),    32'd1);
        check_eq("wrap_row",  32'(cmd_row),   32'h0042);
        check_eq("wrap_open", 32'(bank_open), 32'd0);
        drive(1'b0, 1'b0, P_MRS, 0, 0);
        settle();
        check_eq("cke0_valid", 32'(cmd_valid), 32'd0);
        drive(1'b1, 1'b1, P_ACT, 0, 0);
        settle();
        check_eq("csn1_valid", 32'(cmd_valid), 32'd0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      cmd(P_ACT, $urandom_range(0, 7), $urandom_range(0, 65535));
            else if (r < 50) cmd(P_RD,  $urandom_range(0, 7), $urandom_range(0, 65535));
            else if (r < 65) cmd(P_WR,  $urandom_range(0, 7), $urandom_range(0, 65535));
            else if (r < 80) cmd(P_PRE, $urandom_range(0, 7), $urandom_range(0, 65535));
            else if (r < 81) cmd(P_REF, 0, 0);
            else if (r < 82) cmd(P_MRS, $urandom_range(0, 7), $urandom_range(0, 65535));
            else if (r < 84) cmd(P_ILL, 0, 0);
            else if (r < 93) cmd(P_NOP, 0, 0);
            else if (r < 96) drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), 0, 0);
            else             drive(1'b0, 1'b0, 3'($urandom_range(0, 7)), 0, 0);
        end

        // ILLEGAL flood saturates the counter; reset mid-stream clears all
        do_reset();
        sb_en = 1'b0;
        for (int i = 0; i < 69997; i++) cmd(P_ILL, 0, 0);
        sb_en = 1'b1;
        for (int i = 0; i < 3; i++) cmd(P_ILL, 0, 0);
        settle();
        check_eq("sat_cnt",  32'(err_cnt),  32'hFFFF);
        check_eq("sat_code", 32'(cmd_code), 32'd7);
        apply_reset();
        cmd(P_ACT, 6, 16'h0abc);
        settle();
        check_eq("after_flood_cnt",  32'(err_cnt),   32'd0);
        check_eq("after_flood_open", 32'(bank_open), 32'h40);
        nops(2);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
